// File: rtl/seq_multiplier.sv
// ----------------------------------------------------------------------------
// seq_multiplier : shift-add multiplier producing a 2*Width product in Width+1 cycles
// Optional signed mode enabled by defining SEQ_MUL_SIGNED_EN.   Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module seq_multiplier #(
  parameter int Width = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [Width-1:0] a,
  input  logic [Width-1:0] b,
`ifdef SEQ_MUL_SIGNED_EN
  input  logic             signed_op,
`endif
  output logic             busy,
  output logic             done,
  output logic [Width-1:0] result_hi,
  output logic [Width-1:0] result_lo
);

  localparam int c_cnt_w = $clog2(Width + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic [Width-1:0]       r_mcand;
  logic [2*Width-1:0]     r_acc;
  logic [c_cnt_w-1:0]     r_count;

  logic                   w_accept;
  logic                   w_last;
  logic [Width-1:0]       w_a_mag;
  logic [Width-1:0]       w_b_mag;
  logic [Width-1:0]       w_addend;
  logic [Width:0]         w_sum;
  logic [2*Width-1:0]     w_acc_shift;
  logic [2*Width-1:0]     w_product;

  assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_last   = (r_state == S_RUN) && (r_count == c_cnt_w'(1));

`ifdef SEQ_MUL_SIGNED_EN
  logic w_a_neg;
  logic w_b_neg;
  logic r_neg;

  // Most-negative operands negate to themselves, which is the correct unsigned magnitude.
  assign w_a_neg   = signed_op & a[Width-1];
  assign w_b_neg   = signed_op & b[Width-1];
  assign w_a_mag   = w_a_neg ? -a : a;
  assign w_b_mag   = w_b_neg ? -b : b;
  assign w_product = r_neg ? -w_acc_shift : w_acc_shift;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_neg <= 1'b0;
    end else if (w_accept) begin
      r_neg <= w_a_neg ^ w_b_neg;
    end
  end
`else
  assign w_a_mag   = a;
  assign w_b_mag   = b;
  assign w_product = w_acc_shift;
`endif

  // Carry of the partial add re-enters the accumulator through the shift.
  assign w_addend    = r_acc[0] ? r_mcand : '0;
  assign w_sum       = {1'b0, r_acc[2*Width-1:Width]} + {1'b0, w_addend};
  assign w_acc_shift = {w_sum, r_acc[Width-1:1]};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (w_last) w_next = S_DONE;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = start ? S_RUN : S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_mcand   <= '0;
      r_acc     <= '0;
      r_count   <= '0;
      result_hi <= '0;
      result_lo <= '0;
    end else if (w_accept) begin
      r_mcand <= w_a_mag;
      r_acc   <= {{Width{1'b0}}, w_b_mag};
      r_count <= c_cnt_w'(Width);
    end else if (r_state == S_RUN) begin
      r_acc   <= w_acc_shift;
      r_count <= r_count - c_cnt_w'(1);
      if (w_last) begin
        {result_hi, result_lo} <= w_product;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seq_multiplier.sv
// ----------------------------------------------------------------------------
// tb_seq_multiplier : directed bench with an edge-counting reference model
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_seq_multiplier;

  localparam int W = 32;

  logic          clock;
  logic          reset;
  logic          start;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          signed_op;
  logic          busy;
  logic          done;
  logic [W-1:0]  result_hi;
  logic [W-1:0]  result_lo;

  int checks   = 0;
  int failures = 0;

  seq_multiplier #(.Width(W)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .a         (a),
    .b         (b),
`ifdef SEQ_MUL_SIGNED_EN
    .signed_op (signed_op),
`endif
    .busy      (busy),
    .done      (done),
    .result_hi (result_hi),
    .result_lo (result_lo)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, want);
    end
  endtask

  function automatic logic [63:0] model_prod(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic s);
    logic signed [63:0] sx;
    logic signed [63:0] sy;
    sx = $signed({{W{x[W-1]}}, x});
    sy = $signed({{W{y[W-1]}}, y});
    if (s) return 64'(sx * sy);
    return {32'b0, x} * {32'b0, y};
  endfunction

  // Reference model: an accepted op at edge N completes at edge N+W; a new op
  // may be accepted from edge N+W+1 onwards.
  int          ecnt     = 0;
  int          n_acc    = 0;
  bit          op_valid = 1'b0;
  logic [63:0] op_prod  = '0;
  logic [63:0] held     = '0;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      op_valid = 1'b0;
      held     = '0;
    end else begin
      ecnt++;
      if (op_valid && ecnt == n_acc + W) held = op_prod;
      if (start && (!op_valid || ecnt >= n_acc + W + 1)) begin
        op_valid = 1'b1;
        n_acc    = ecnt;
        op_prod  = model_prod(a, b, signed_op);
      end
    end
  end

  always @(negedge clock) begin
    if (!reset) begin
      check("model_busy", 64'(busy), 64'(op_valid && (ecnt < n_acc + W)));
      check("model_done", 64'(done), 64'(op_valid && (ecnt == n_acc + W)));
      check("model_result", {result_hi, result_lo}, held);
    end
  end

  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                        input logic [63:0] want, input string nm);
    int k;
    int nb;
    @(negedge clock);
    a = x; b = y; signed_op = s; start = 1'b1;
    @(negedge clock);
    start = 1'b0; a = ~x; b = ~y; signed_op = ~s;
    k  = 0;
    nb = 0;
    while (!done && k < 40) begin
      if (busy) nb++;
      @(negedge clock);
      k++;
    end
    if (k >= 40) begin
      failures++;
      $display("FAIL %s_timeout actual=no_done required=done_within_40", nm);
    end else begin
      check({nm, "_latency"}, 64'(k), 64'(W));
      check({nm, "_busy_cycles"}, 64'(nb), 64'(W));
      check({nm, "_product"}, {result_hi, result_lo}, want);
    end
  endtask

  initial begin
    int seen;
    int pulses;
    int last_i;
    reset = 1'b1; start = 1'b0; a = '0; b = '0; signed_op = 1'b0;
    repeat (3) @(negedge clock);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_result", {result_hi, result_lo}, 64'd0);
    reset = 1'b0;

    run_op(32'd7, 32'd6, 1'b0, 64'd42, "mul_7x6");
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, "mul_max");
    run_op(32'd0, 32'd123, 1'b0, 64'd0, "mul_a_zero");
    run_op(32'h1234_5678, 32'd0, 1'b0, 64'd0, "mul_b_zero");
    run_op(32'h8000_0000, 32'd2, 1'b0, 64'h0000_0001_0000_0000, "mul_carry");
    run_op(32'h0001_0001, 32'hFFFF_0000, 1'b0, 64'h0000_FFFF_FFFF_0000, "mul_mixed");

    // Abort mid-run: previous nonzero product must clear at once.
    @(negedge clock);
    a = 32'd7; b = 32'd6; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (9) @(negedge clock);
    reset = 1'b1;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_result", {result_hi, result_lo}, 64'd0);
    @(negedge clock);
    reset = 1'b0;
    seen = 0;
    repeat (40) begin
      @(negedge clock);
      if (done) seen++;
    end
    check("abort_no_done", 64'(seen), 64'd0);
    run_op(32'd7, 32'd6, 1'b0, 64'd42, "after_abort");

    // start held high; operands disturbed only while running.
    @(negedge clock);
    a = 32'd3; b = 32'd5; start = 1'b1;
    pulses = 0;
    last_i = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (done) begin
        pulses++;
        check("held_result", {result_hi, result_lo}, 64'd15);
        if (last_i >= 0) check("held_spacing", 64'(i - last_i), 64'(W + 1));
        last_i = i;
      end
      if (busy) begin a = 32'd9; b = 32'd11; end
      else begin a = 32'd3; b = 32'd5; end
    end
    start = 1'b0;
    check("held_pulses", 64'(pulses), 64'd3);
    seen = 0;
    for (int i = 0; i < 40 && seen == 0; i++) begin
      @(negedge clock);
      if (done) seen = 1;
    end
    check("held_drain_done", 64'(seen), 64'd1);
    check("held_drain_result", {result_hi, result_lo}, 64'd15);

`ifdef SEQ_MUL_SIGNED_EN
    run_op(32'hFFFF_FFFD, 32'd5, 1'b1, 64'hFFFF_FFFF_FFFF_FFF1, "signed_neg3x5");
    run_op(32'hFFFF_FFFD, 32'd5, 1'b0, 64'h0000_0004_FFFF_FFF1, "unsigned_same");
    run_op(32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, "signed_minmin");
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'd1, "signed_m1m1");
`endif

    repeat (3) @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire

// File: doc/seq_multiplier.md
Name: seq_multiplier

Overview:
- Multi-cycle shift-add multiplier in the datapath, directly upstream of the result registers (HI/LO).
- `done` is a one-cycle pulse intended to drive the `load` of those registers.
- `result_hi`/`result_lo` feed their `in` ports.
- One operand pair is processed at a time, with a start/busy/done handshake from the control unit.

Parameters:
- Width, 32, operand width in bits; each result half is Width bits. Legal range 2..64.

Ports:
- clock  input  1  system clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled on posedge; accepted only in IDLE or DONE.
- a  input  Width  multiplicand; sampled when start is accepted.
- b  input  Width  multiplier; sampled when start is accepted.
- signed_op  input  1  present only with SEQ_MUL_SIGNED_EN; sampled with a/b.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; result valid in this cycle.
- result_hi  output  Width  upper half of the 2*Width product.
- result_lo  output  Width  lower half of the 2*Width product.

Behaviour:
- Reset (async, active-high):
  - State goes to IDLE.
  - busy=0, done=0, result_hi=0, result_lo=0.
  - Internal accumulator, multiplicand and counter are cleared.
  - Reset asserted mid-RUN aborts the operation; no done pulse follows.
- States: IDLE, RUN, DONE.
  - IDLE: if start=1 at a posedge, latch a into the multiplicand register. Load the accumulator as {Width'0, b}. Set count=Width and go to RUN. Otherwise stay.
  - RUN: busy=1 and start is ignored. Each posedge:
    - If acc[0]=1, add the multiplicand to acc[2W-1:W] with a W+1-bit sum.
    - Shift {carry, acc} right by 1.
    - Decrement count.
    - When count reaches 1 on this edge, the next state is DONE.
  - DONE: done=1 for exactly one cycle; busy=0. Next posedge: if start=1, accept a new operation exactly as IDLE does and go to RUN; otherwise go to IDLE.
- Latency:
  - start sampled at edge N, so the RUN cycles are edges N+1..N+Width.
  - done is high during the cycle after edge N+Width.
  - Back-to-back throughput is one result per Width+1 cycles.
- Outputs:
  - result_hi/result_lo are driven from the accumulator only when the operation completes.
  - They hold the last product stable through IDLE and the following RUN, until the next DONE.
- Arithmetic:
  - Exact unsigned product, 2*Width bits, no overflow possible.
  - The carry out of each partial add is kept via the W+1-bit sum.
- Boundaries:
  - start held high continuously gives one operation per Width+1 cycles. start during RUN is never queued.
  - a=0 or b=0 yields 0 and still takes full latency; no early termination.
  - Changes to a/b/signed_op after acceptance have no effect.
  - Counter width is $clog2(Width+1); it must not wrap for Width=64.

Optional Feature:
- Macro: SEQ_MUL_SIGNED_EN.
- Defined:
  - The signed_op port exists.
  - When signed_op=1 at acceptance, a and b are treated as two's complement. Their magnitudes are multiplied and the sign flag (a[W-1]^b[W-1]) is latched.
  - At completion, if the sign flag is set, the 2*Width product is two's-complement negated before loading result_hi/result_lo.
  - Latency is unchanged (negation happens on the RUN→DONE edge).
  - Most-negative operands (e.g. 0x80000000*0x80000000) give the correct +2^62.
- Undefined: no signed_op port; unsigned only; no negation logic.

Test Plan:
- Reset mid-RUN: assert reset at RUN cycle 10 → busy=0, done=0, results=0 immediately. No done pulse follows; the next start works normally.
- Width=32, a=7, b=6, start for one cycle at edge N → busy high for 32 cycles. done high exactly in the cycle after edge N+32, with result_hi=0 and result_lo=42.
- a=0xFFFFFFFF, b=0xFFFFFFFF → result_hi=0xFFFFFFFE, result_lo=0x00000001.
- start held high for 100 cycles with a=3, b=5 → done pulses every 33 cycles. result_lo=15 after each pulse; start during RUN is ignored, and a/b changed mid-RUN do not alter the result.
- SEQ_MUL_SIGNED_EN, signed_op=1, a=0xFFFFFFFD (-3), b=5 → result_hi=0xFFFFFFFF, result_lo=0xFFFFFFF1.
- SEQ_MUL_SIGNED_EN, signed_op=0 with the same operands → unsigned product 0x00000004_FFFFFFF1.
